multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit that sequences the multicycle RV32I datapath and the unified instruction/data memory.
- Comprises a Moore main FSM, an ALU decoder and an immediate-select decoder.
- Drives every datapath enable and mux select. Consumes opcode/funct fields from the instruction register and the ALU Zero flag.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: an unsupported opcode parks the FSM in HALT. 0: the instruction is skipped and the FSM returns to FETCH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- op  input  7  Instr[6:0]
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- zero  input  1  ALU result == 0
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data
- ALUSrcB  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  output  1  0 PC, 1 Result
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IRWrite  output  1  instruction register enable
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register file write enable
- MemWrite  output  1  memory write enable
- illegal  output  1  high while in HALT

Behaviour:
- All outputs are decoded from state only, except:
  - PCWrite = PCUpdate | (Branch & zero).
  - ALUControl is combinational from ALUOp, funct3, funct7b5 and op[5].
- Any output not listed for a state is 0.

Reset:
- Any rising edge with reset==0 sets state to FETCH.
- While reset==0, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0 combinationally.
- All other outputs take their FETCH values; illegal=0.
- Reset asserted in any state, including HALT, wins over the next-state logic.

States (state: asserted signals -> next state):
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; computes the branch target. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> HALT if HALT_ON_ILLEGAL, else FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op[5]==0, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- HALT: illegal=1, all enables 0 -> HALT until reset.
- Unreachable state encodings -> FETCH on the next edge.

Cycles per instruction (counted from FETCH):
- lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3; illegal with HALT_ON_ILLEGAL=0: 2.

ALU decoder:
- ALUOp 00 -> add; 01 -> sub.
- ALUOp 10, by funct3:
  - 000 -> sub if (funct7b5 & op[5]), else add; addi is never sub.
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - any other funct3 -> add

ImmSrc (combinational on op, valid in every state):
- 0000011 or 0010011 -> 00
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- otherwise -> 00

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined: adds outputs cycle_count[31:0] and instret[31:0].
  - Both clear to 0 while reset==0.
  - cycle_count increments every non-HALT cycle.
  - instret increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both wrap modulo 2^32.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset held low for 2 edges, op=0110011 -> FETCH outputs with IRWrite=PCWrite=0 during reset; after release, FETCH asserts IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op=0000011, funct3=010) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; MemWrite never high.
- sw (op=0100011) -> MemWrite=1 only in cycle 4 with AdrSrc=1; ImmSrc=01 throughout.
- R sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. addi with funct7b5=1 -> ALUControl=000. funct3=111 -> 010; 110 -> 011; 010 -> 101.
- beq with zero=1 -> PCWrite=1 in cycle 3; beq with zero=0 -> PCWrite=0; both return to FETCH.
- jal (op=1101111) -> PCWrite=1 in JAL, RegWrite=1 in ALUWB, 4 cycles. op=1111111 -> illegal=1 and held with no enables; reset clears it.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM, ALU decoder and immediate-select decoder for the multicycle RV32I datapath.
// Define MULTICYCLE_PERF_EN to add the cycle_count/instret performance counters.
module multicycle_controller #(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic [2:0] ALUControl,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       illegal
`ifdef MULTICYCLE_PERF_EN
   , output logic [31:0] cycle_count
   , output logic [31:0] instret
`endif
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT
   } state_t;
   typedef struct packed {
      logic [1:0] asa, asb, rs;
      logic       adr;
      logic [1:0] aluop;
      logic       irw, pcu, br, rw, mw, ill;
   } ctl_t;
   function automatic ctl_t dec(input state_t s);
      ctl_t c = '0;
      case (s)
         FETCH:    begin c.irw = 1'b1; c.asb = 2'b10; c.rs = 2'b10; c.pcu = 1'b1; end
         DECODE:   begin c.asa = 2'b01; c.asb = 2'b01; end
         MEMADR:   begin c.asa = 2'b10; c.asb = 2'b01; end
         MEMREAD:  c.adr = 1'b1;
         MEMWB:    begin c.rs = 2'b01; c.rw = 1'b1; end
         MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; end
         EXECUTER: begin c.asa = 2'b10; c.aluop = 2'b10; end
         EXECUTEI: begin c.asa = 2'b10; c.asb = 2'b01; c.aluop = 2'b10; end
         ALUWB:    c.rw = 1'b1;
         BEQ:      begin c.asa = 2'b10; c.aluop = 2'b01; c.br = 1'b1; end
         JAL:      begin c.asa = 2'b01; c.asb = 2'b10; c.pcu = 1'b1; end
         HALT:     c.ill = 1'b1;
         default:  ;
      endcase
      return c;
   endfunction
   function automatic state_t nxt(input state_t s, input logic [6:0] o);
      case (s)
         FETCH:    return DECODE;
         DECODE:
            case (o)
               7'b0000011, 7'b0100011: return MEMADR;
               7'b0110011:             return EXECUTER;
               7'b0010011:             return EXECUTEI;
               7'b1100011:             return BEQ;
               7'b1101111:             return JAL;
               default:                return HALT_ON_ILLEGAL ? HALT : FETCH;
            endcase
         MEMADR:   return o[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  return MEMWB;
         EXECUTER: return ALUWB;
         EXECUTEI: return ALUWB;
         JAL:      return ALUWB;
         HALT:     return HALT;
         default:  return FETCH;
      endcase
   endfunction
   state_t state_q, state_d;
   ctl_t   ctl_q;
   always_comb state_d = nxt(state_q, op);
   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         ctl_q   <= dec(FETCH);
      end else begin
         state_q <= state_d;
         ctl_q   <= dec(state_d);
      end
   end
   assign ALUSrcA   = ctl_q.asa;
   assign ALUSrcB   = ctl_q.asb;
   assign ResultSrc = ctl_q.rs;
   assign AdrSrc    = ctl_q.adr;
   assign IRWrite   = reset & ctl_q.irw;
   assign PCWrite   = reset & (ctl_q.pcu | (ctl_q.br & zero));
   assign RegWrite  = reset & ctl_q.rw;
   assign MemWrite  = reset & ctl_q.mw;
   assign illegal   = reset & ctl_q.ill;
   always_comb
      ImmSrc = (op == 7'b0100011) ? 2'b01 :
               (op == 7'b1100011) ? 2'b10 :
               (op == 7'b1101111) ? 2'b11 : 2'b00;
   always_comb
      ALUControl = (ctl_q.aluop == 2'b00) ? 3'b000 :
                   (ctl_q.aluop == 2'b01) ? 3'b001 :
                   (funct3 == 3'b000)     ? ((funct7b5 & op[5]) ? 3'b001 : 3'b000) :
                   (funct3 == 3'b010)     ? 3'b101 :
                   (funct3 == 3'b110)     ? 3'b011 :
                   (funct3 == 3'b111)     ? 3'b010 : 3'b000;
`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_q, instret_q;
   // Every retiring state hands control straight back to FETCH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state_q != HALT) cycle_q <= cycle_q + 32'd1;
         if (state_q inside {MEMWB, MEMWRITE, ALUWB, BEQ}) instret_q <= instret_q + 32'd1;
      end
   end
   assign cycle_count = cycle_q;
   assign instret     = instret_q;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle vector table for multicycle_controller, checked through an expected-value queue.
module tb_multicycle_controller;
   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
   localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, IL = 7'b1111111;
   logic       clk = 1'b0, reset = 1'b0, funct7b5 = 1'b0, zero = 1'b0;
   logic [6:0] op = RT;
   logic [2:0] funct3 = 3'b000;
   logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ALUControl;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal;
   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal(illegal)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7, z, chk;
      logic [16:0] exp;
      string       name;
   } vec_t;
   typedef struct {
      logic [16:0] exp;
      string       name;
   } sb_t;
   vec_t vec[$];
   sb_t  sb[$];
   int   checks = 0, failures = 0;
   function automatic logic [16:0] e(input logic [1:0] imm, asa, asb, rs, input logic adr,
                                     input logic [2:0] alu, input logic irw, pcw, rw, mw, ill);
      return {imm, asa, asb, rs, adr, alu, irw, pcw, rw, mw, ill};
   endfunction
   task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7, z, chk,
                      input logic [16:0] x, input string n);
      vec_t v;
      v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.chk = chk; v.exp = x; v.name = n;
      vec.push_back(v);
   endtask
   task automatic fetch(input logic [6:0] o, input logic [2:0] f3, input logic f7, z, input logic [1:0] imm, input string n);
      add(1, o, f3, f7, z, 1, e(imm, 0, 2, 2, 0, 0, 1, 1, 0, 0, 0), {n, "_fetch"});
      add(1, o, f3, f7, z, 1, e(imm, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), {n, "_decode"});
   endtask
   initial begin
      logic [16:0] act;
      sb_t s;
      add(0, RT, 0, 0, 0, 1, e(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0), "rst_hold0");
      add(0, RT, 0, 0, 0, 1, e(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0), "rst_hold1");
      fetch(LW, 3'b010, 0, 1, 0, "lw");
      add(1, LW, 3'b010, 0, 1, 1, e(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lw_memadr");
      add(1, LW, 3'b010, 0, 1, 1, e(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "lw_memread");
      add(1, LW, 3'b010, 0, 1, 1, e(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0), "lw_memwb");
      fetch(SW, 3'b010, 0, 0, 1, "sw");
      add(1, SW, 3'b010, 0, 0, 1, e(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw_memadr");
      add(1, SW, 3'b010, 0, 0, 1, e(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "sw_memwrite");
      fetch(RT, 3'b000, 1, 0, 0, "sub");
      add(1, RT, 3'b000, 1, 0, 1, e(0, 2, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0), "sub_exec");
      add(1, RT, 3'b000, 1, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "sub_aluwb");
      fetch(IT, 3'b000, 1, 0, 0, "addi");
      add(1, IT, 3'b000, 1, 0, 1, e(0, 2, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0), "addi_exec");
      add(1, IT, 3'b000, 1, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "addi_aluwb");
      fetch(RT, 3'b111, 0, 0, 0, "and");
      add(1, RT, 3'b111, 0, 0, 1, e(0, 2, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0), "and_exec");
      add(1, RT, 3'b111, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "and_aluwb");
      fetch(IT, 3'b110, 0, 0, 0, "ori");
      add(1, IT, 3'b110, 0, 0, 1, e(0, 2, 1, 0, 0, 3'b011, 0, 0, 0, 0, 0), "ori_exec");
      add(1, IT, 3'b110, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "ori_aluwb");
      fetch(RT, 3'b010, 0, 0, 0, "slt");
      add(1, RT, 3'b010, 0, 0, 1, e(0, 2, 0, 0, 0, 3'b101, 0, 0, 0, 0, 0), "slt_exec");
      add(1, RT, 3'b010, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "slt_aluwb");
      fetch(BQ, 3'b000, 0, 1, 2, "beqt");
      add(1, BQ, 3'b000, 0, 1, 1, e(2, 2, 0, 0, 0, 3'b001, 0, 1, 0, 0, 0), "beqt_beq");
      fetch(BQ, 3'b000, 0, 0, 2, "beqn");
      add(1, BQ, 3'b000, 0, 0, 1, e(2, 2, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0), "beqn_beq");
      fetch(JL, 3'b000, 0, 0, 3, "jal");
      add(1, JL, 3'b000, 0, 0, 1, e(3, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0), "jal_jal");
      add(1, JL, 3'b000, 0, 0, 1, e(3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "jal_aluwb");
      fetch(IL, 3'b000, 0, 1, 0, "ill");
      add(1, IL, 3'b000, 0, 1, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_halt0");
      add(1, IL, 3'b000, 0, 1, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_halt1");
      add(0, IL, 3'b000, 0, 1, 0, '0, "ill_rst_edge");
      add(0, IL, 3'b000, 0, 1, 1, e(0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0), "ill_rst_fetch");
      fetch(RT, 3'b000, 0, 0, 0, "add");
      add(1, RT, 3'b000, 0, 0, 1, e(0, 2, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0), "add_exec");
      add(1, RT, 3'b000, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "add_aluwb");
      fetch(RT, 3'b000, 0, 0, 0, "back");
      @(posedge clk);
      #1;
      foreach (vec[i]) begin
         reset = vec[i].rst; op = vec[i].op; funct3 = vec[i].f3; funct7b5 = vec[i].f7; zero = vec[i].z;
         if (vec[i].chk) begin
            s.exp = vec[i].exp; s.name = vec[i].name;
            sb.push_back(s);
         end
         @(negedge clk);
         if (vec[i].chk) begin
            checks++;
            s = sb.pop_front();
            act = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite, RegWrite, MemWrite, illegal};
            if (act !== s.exp) begin
               failures++;
               $display("FAIL %s: got %05h expected %05h", s.name, act, s.exp);
            end
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
